// File: rtl/serial_lane_write_queue.sv
// serial_lane_write_queue: DEPTH-entry word FIFO feeding a shifter that drives LANES bits per write_sig strobe
module serial_lane_write_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES = 1,
  parameter int DEPTH = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  input  logic                         write_sig,
  input  logic                         abort,
  output logic [LANES-1:0]             data_out,
  output logic                         busy,
  output logic                         word_done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
  localparam int BEATS = DATA_WIDTH / LANES;
  localparam int CW = $clog2(BEATS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [1:0] S_RESET = 2'd0, S_IDLE = 2'd1, S_SHIFT = 2'd2;
  logic [1:0] state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0] ctr;
  logic [LANES-1:0] beat;
  logic last, pop, push, step;
  assign last = state == S_SHIFT && ctr == CW'(BEATS);
  assign pop = fifo_level != '0 && (state == S_IDLE || last);
  assign in_ready = fifo_level < LW'(DEPTH) && state != S_RESET;
  assign push = in_valid && in_ready && !abort;
  assign step = state == S_SHIFT && write_sig && ctr < CW'(BEATS);
  assign beat = MSB_FIRST ? shreg[DATA_WIDTH-1 -: LANES] : shreg[LANES-1:0];
  always_ff @(posedge sys_clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      state <= S_RESET;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      shreg <= '0;
      ctr <= '0;
      data_out <= {LANES{IDLE_LEVEL}};
      busy <= 1'b0;
      word_done <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      shreg <= '0;
      ctr <= '0;
      data_out <= {LANES{IDLE_LEVEL}};
      busy <= 1'b0;
      word_done <= 1'b0;
    end else if (state == S_RESET) begin
      state <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      shreg <= '0;
      ctr <= '0;
      busy <= 1'b0;
      word_done <= 1'b0;
    end else if (state != S_IDLE && state != S_SHIFT) begin
      state <= S_RESET;
    end else begin
      word_done <= last;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shreg <= mem[rd_ptr];
        ctr <= '0;
        busy <= 1'b1;
        state <= S_SHIFT;
      end else if (step) begin
        shreg <= MSB_FIRST ? shreg << LANES : shreg >> LANES;
        ctr <= ctr + 1'b1;
        data_out <= beat;
      end else if (last) begin
        busy <= 1'b0;
        state <= S_IDLE;
      end
    end
endmodule

// File: tb/tb_serial_lane_write_queue.sv
// tb_serial_lane_write_queue: directed vectors for MSB/LSB single-lane and 4-lane queue instances
module tb_serial_lane_write_queue;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  always #5 sys_clk = ~sys_clk;
  logic in_valid = 1'b0, write_sig = 1'b0, abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic rdy0, rdy1, busy0, busy1, wd0, wd1;
  logic [0:0] do0, do1;
  logic [2:0] lv0, lv1;
  logic v2 = 1'b0, ws2 = 1'b0, ab2 = 1'b0;
  logic [7:0] d2 = 8'h00;
  logic rdy2, busy2, wd2;
  logic [3:0] do2;
  logic [2:0] lv2;
  int n_vec = 0, n_miss = 0;
  int wc0 = 0, wc1 = 0, wc2 = 0;

  serial_lane_write_queue #(.DATA_WIDTH(8), .LANES(1), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
    .write_sig(write_sig), .abort(abort), .data_out(do0), .busy(busy0), .word_done(wd0), .fifo_level(lv0));
  serial_lane_write_queue #(.DATA_WIDTH(8), .LANES(1), .DEPTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .sys_clk(sys_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy1),
    .write_sig(write_sig), .abort(abort), .data_out(do1), .busy(busy1), .word_done(wd1), .fifo_level(lv1));
  serial_lane_write_queue #(.DATA_WIDTH(8), .LANES(4), .DEPTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_quad (
    .sys_clk(sys_clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
    .write_sig(ws2), .abort(ab2), .data_out(do2), .busy(busy2), .word_done(wd2), .fifo_level(lv2));

  always @(posedge sys_clk) begin
    if (wd0 === 1'b1) wc0 <= wc0 + 1;
    if (wd1 === 1'b1) wc1 <= wc1 + 1;
    if (wd2 === 1'b1) wc2 <= wc2 + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;
  vec_t tbl [4];
  logic [7:0] words [6];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    for (int k = 0; k < 20 && rdy0 !== 1'b1; k++) tick(1);
    chk("push_ready", rdy0, 1'b1);
    tick(1);
    in_valid = 1'b0;
    tick(1);
  endtask

  task automatic beat(output logic a0, output logic a1);
    write_sig = 1'b1;
    tick(1);
    write_sig = 1'b0;
    a0 = do0;
    a1 = do1;
    tick(3);
  endtask

  task automatic send(input logic [7:0] w);
    logic a0, a1;
    for (int b = 0; b < 8; b++) begin
      beat(a0, a1);
      chk("msb_bit", a0, w[7-b]);
      chk("lsb_bit", a1, w[b]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic a0, a1;
    int base0, base1;
    tbl[0] = '{8'hA5, 8'hA5, 8'hA5};
    tbl[1] = '{8'h01, 8'h01, 8'h80};
    tbl[2] = '{8'hC1, 8'hC1, 8'h83};
    tbl[3] = '{8'h3E, 8'h3E, 8'h7C};
    words = '{8'h11, 8'h22, 8'h44, 8'h88, 8'h0F, 8'hF0};
    #1;
    chk("rst_data", do0, 1'b0);
    chk("rst_ready", rdy0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", wd0, 1'b0);
    chk("rst_level", lv0, 3'd0);
    tick(2);
    rst = 1'b0;
    chk("ready_in_reset_state", rdy0, 1'b0);
    tick(1);
    chk("ready_after_reset", rdy0, 1'b1);
    write_sig = 1'b1;
    tick(1);
    write_sig = 1'b0;
    chk("idle_strobe_ignored", do0, 1'b0);
    chk("idle_not_busy", busy0, 1'b0);

    foreach (tbl[i]) begin
      base0 = wc0;
      base1 = wc1;
      push(tbl[i].data);
      chk("tbl_busy", busy0, 1'b1);
      for (int b = 0; b < 8; b++) begin
        beat(a0, a1);
        chk("tbl_msb_beat", a0, tbl[i].exp_msb[7-b]);
        chk("tbl_lsb_beat", a1, tbl[i].exp_lsb[7-b]);
      end
      chk("tbl_done_msb", 8'(wc0 - base0), 8'd1);
      chk("tbl_done_lsb", 8'(wc1 - base1), 8'd1);
      chk("tbl_idle", busy0, 1'b0);
      chk("tbl_hold_msb", do0, tbl[i].exp_msb[0]);
      chk("tbl_hold_lsb", do1, tbl[i].exp_lsb[0]);
    end

    v2 = 1'b1;
    d2 = 8'h3C;
    chk("quad_ready", rdy2, 1'b1);
    tick(1);
    d2 = 8'h81;
    tick(1);
    v2 = 1'b0;
    chk("quad_level", lv2, 3'd1);
    chk("quad_busy", busy2, 1'b1);
    ws2 = 1'b1; tick(1); ws2 = 1'b0;
    chk("quad_beat0", do2, 4'h3);
    tick(1);
    ws2 = 1'b1; tick(1); ws2 = 1'b0;
    chk("quad_beat1", do2, 4'hC);
    ws2 = 1'b1; tick(1); ws2 = 1'b0;
    chk("quad_ignored", do2, 4'hC);
    chk("quad_done1", wd2, 1'b1);
    chk("quad_reload_level", lv2, 3'd0);
    tick(1);
    ws2 = 1'b1; tick(1); ws2 = 1'b0;
    chk("quad_beat2", do2, 4'h8);
    tick(1);
    ws2 = 1'b1; tick(1); ws2 = 1'b0;
    chk("quad_beat3", do2, 4'h1);
    tick(1);
    chk("quad_done2", wd2, 1'b1);
    chk("quad_idle", busy2, 1'b0);
    tick(2);
    chk("quad_done_count", 8'(wc2), 8'd2);
    chk("quad_hold", do2, 4'h1);

    base0 = wc0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = words[i];
      chk("fill_ready", rdy0, 1'b1);
      tick(1);
    end
    in_data = words[5];
    chk("full_level", lv0, 3'd4);
    chk("full_ready", rdy0, 1'b0);
    chk("full_busy", busy0, 1'b1);
    tick(3);
    chk("full_held_level", lv0, 3'd4);
    send(words[0]);
    in_valid = 1'b0;
    chk("refill_level", lv0, 3'd4);
    for (int i = 1; i < 6; i++) send(words[i]);
    chk("drain_level", lv0, 3'd0);
    chk("drain_busy", busy0, 1'b0);
    chk("drain_done_count", 8'(wc0 - base0), 8'd6);

    base0 = wc0;
    push(8'hFF);
    for (int b = 0; b < 3; b++) begin
      beat(a0, a1);
      chk("pre_abort_bit", a0, 1'b1);
    end
    in_valid = 1'b1;
    in_data = 8'h00;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_data_msb", do0, 1'b0);
    chk("abort_data_lsb", do1, 1'b0);
    chk("abort_level", lv0, 3'd0);
    chk("abort_busy", busy0, 1'b0);
    chk("abort_done", wd0, 1'b0);
    chk("abort_ready", rdy0, 1'b1);
    tick(3);
    chk("abort_no_done", 8'(wc0 - base0), 8'd0);
    chk("abort_still_empty", lv0, 3'd0);
    push(8'h96);
    send(8'h96);
    chk("post_abort_done", 8'(wc0 - base0), 8'd1);

    push(8'hFF);
    for (int b = 0; b < 4; b++) beat(a0, a1);
    chk("pre_rst_data", do0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_data_msb", do0, 1'b0);
    chk("async_rst_data_lsb", do1, 1'b0);
    chk("async_rst_data_quad", do2, 4'h0);
    chk("async_rst_busy", busy0, 1'b0);
    chk("async_rst_ready", rdy0, 1'b0);
    chk("async_rst_level", lv0, 3'd0);
    tick(1);
    rst = 1'b0;
    chk("release_ready", rdy0, 1'b0);
    tick(2);
    chk("release_ready_later", rdy0, 1'b1);
    chk("release_busy", busy0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
